mem_rw_arb: RTL and testbench

MEM_RW_ARB -- requirements
Module: mem_rw_arb

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_rw_arb.sv | 153 +++++++++++++++
 tb/tb_mem_rw_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read/write arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int REQ_PANEL = 0;
  localparam int REQ_CORE  = 1;
  localparam int REQ_SNAP  = 2;

  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 8;
  localparam int DEF_DW   = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: search starts just after ptr_i and wraps; first set request wins.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [IW-1:0]   idx_o,
  output logic [NREQ-1:0] oh_o
);

  int w_j;

  // Rotate by the pointer, priority-encode, and emit both index and one-hot.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    oh_o  = '0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(ptr_i) + 1 + k) % NREQ;
      if (!any_o && req_i[w_j]) begin
        any_o     = 1'b1;
        idx_o     = IW'(w_j);
        oh_o[w_j] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mem_rw_arb.sv
// Arbitrates NREQ requesters onto one memory rw-port with an IDLE/OWN FSM.
// Define MEM_ARB_RR_EN for round-robin selection; fixed priority otherwise.
module mem_rw_arb
  import mem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]    req_val_i,
  input  logic [NREQ-1:0]    req_wen_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_rdy_o,
  output logic [NREQ-1:0]    req_rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic             m_val_o,
  output logic             m_wen_o,
  output logic [AW-1:0]      m_addr_o,
  output logic [DW-1:0]      m_wdata_o,
  input  logic             m_rdy_i,
  input  logic [DW-1:0]      m_rdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic             busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt, r_rv_owner;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_rvalid;
  logic            w_accept, w_own_val;
  logic            w_pick_any;
  logic [IW-1:0]   w_pick_idx, w_ptr;
  logic [NREQ-1:0] w_pick_oh;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  // Round-robin pointer remembers the last accepted owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= IW'(NREQ - 1);
    end else if (w_accept) begin
      r_ptr <= r_owner;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`else
  // A fixed pointer at the last index makes the search start at index 0.
  assign w_ptr = IW'(NREQ - 1);
`endif

  mem_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (req_val_i),
    .ptr_i (w_ptr),
    .any_o (w_pick_any),
    .idx_o (w_pick_idx),
    .oh_o  (w_pick_oh)
  );

  assign w_own_val = req_val_i[r_owner];

  // Next-state and the combinational memory-port mux; everything forced low in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_accept    = 1'b0;
    m_val_o     = 1'b0;
    m_wen_o     = 1'b0;
    m_addr_o    = '0;
    m_wdata_o   = '0;
    req_rdy_o   = '0;
    busy_o      = 1'b0;
    gnt_o       = r_gnt;
    rdata_o     = m_rdata_i;
    req_rvalid_o = '0;
    if (r_rvalid) begin
      req_rvalid_o[r_rv_owner] = 1'b1;
    end else begin
      req_rvalid_o = '0;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = w_pick_idx;
          w_gnt_nxt   = w_pick_oh;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN: begin
        busy_o    = 1'b1;
        m_val_o   = w_own_val;
        m_wen_o   = req_wen_i[r_owner];
        m_addr_o  = req_addr_i[r_owner*AW +: AW];
        m_wdata_o = req_wdata_i[r_owner*DW +: DW];
        req_rdy_o[r_owner] = m_rdy_i;
        w_accept  = w_own_val && m_rdy_i;
        // Leave on acceptance or when the owner withdraws; no re-arbitration here.
        if (w_accept || !w_own_val) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_OWN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    if (rst_i) begin
      m_val_o      = 1'b0;
      m_wen_o      = 1'b0;
      m_addr_o     = '0;
      m_wdata_o    = '0;
      req_rdy_o    = '0;
      busy_o       = 1'b0;
      gnt_o        = '0;
      rdata_o      = '0;
      req_rvalid_o = '0;
    end else begin
      busy_o = busy_o;
    end
  end

  // State, owner, grant and the one-cycle-late read-valid tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_gnt      <= '0;
      r_rvalid   <= 1'b0;
      r_rv_owner <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rvalid   <= w_accept && !req_wen_i[r_owner];
      r_rv_owner <= r_owner;
    end
  end

endmodule

// File: tb/tb_mem_rw_arb.sv
// Randomized + directed bench for mem_rw_arb against a transaction-level reference model.
module tb_mem_rw_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  val, wen;
  logic [23:0] addr;
  logic [47:0] wdata;
  logic        m_rdy;
  logic [15:0] m_rdata;
  logic [2:0]  rdy, rvalid, gnt;
  logic [15:0] rdata, m_wdata;
  logic        m_val, m_wen, busy;
  logic [7:0]  m_addr;

  mem_rw_arb #(.NREQ(3), .AW(8), .DW(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_val_i(val), .req_wen_i(wen), .req_addr_i(addr), .req_wdata_i(wdata),
    .req_rdy_o(rdy), .req_rvalid_o(rvalid), .rdata_o(rdata),
    .m_val_o(m_val), .m_wen_o(m_wen), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdy_i(m_rdy), .m_rdata_i(m_rdata),
    .gnt_o(gnt), .busy_o(busy)
  );

  // next-cycle stimulus
  logic        n_rst = 1'b1;
  logic [2:0]  n_val = 3'b000, n_wen = 3'b000;
  logic [23:0] n_addr = 24'h0;
  logic [47:0] n_wdata = 48'h0;
  logic        n_mrdy = 1'b0;
  logic [15:0] n_mrdata = 16'h0;
  bit          auto_drop = 1'b1;

  // reference model: is someone owning the port, who, a pending read return, memory image
  bit          own = 1'b0;
  int          owner = 0;
  bit          rv_pend = 1'b0;
  int          rv_who = 0;
  logic [15:0] rv_data = 16'h0;
  int          ptr = 2;
  logic [15:0] mem [256];

  logic [2:0]  s_gnt, s_rvalid, s_rdy;
  logic [15:0] s_rdata;
  logic        s_mval, s_busy;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + 1 + k) % 3]) return (p + 1 + k) % 3;
    end
    return 0;
  endfunction

  task automatic cycle();
    logic [2:0] e_gnt, e_rdy, e_rv;
    bit e_mval, acc, rd;
    int aw;
    @(negedge clk);
    rst = n_rst; val = n_val; wen = n_wen; addr = n_addr; wdata = n_wdata;
    m_rdy = n_mrdy; m_rdata = n_mrdata;
    #1;
    e_gnt = 3'b000; e_rdy = 3'b000; e_rv = 3'b000; e_mval = 1'b0;
    if (!rst && own) begin
      e_gnt = 3'b001 << owner;
      e_mval = val[owner];
      e_rdy = m_rdy ? e_gnt : 3'b000;
    end
    if (!rst && rv_pend) e_rv = 3'b001 << rv_who;
    chk("gnt", gnt, e_gnt);
    chk("busy", busy, (!rst && own));
    chk("m_val", m_val, e_mval);
    chk("rdy", rdy, e_rdy);
    chk("rvalid", rvalid, e_rv);
    if (e_mval) begin
      chk("m_wen", m_wen, wen[owner]);
      chk("m_addr", m_addr, addr[owner*8 +: 8]);
      chk("m_wdata", m_wdata, wdata[owner*16 +: 16]);
    end
    if (e_rv != 3'b000) chk("rdata", rdata, rv_data);
    if (rst) chk("rdata_rst", rdata, 16'h0);
    s_gnt = gnt; s_rvalid = rvalid; s_rdy = rdy; s_rdata = rdata; s_mval = m_val; s_busy = busy;
    @(posedge clk);
    acc = 1'b0; rd = 1'b0;
    if (rst) begin
      own = 1'b0; rv_pend = 1'b0; ptr = 2;
    end else begin
      if (own) begin
        acc = val[owner] && m_rdy;
        aw = int'(addr[owner*8 +: 8]);
        if (acc && !wen[owner]) begin
          rd = 1'b1; rv_who = owner; rv_data = mem[aw];
        end
        if (acc && wen[owner]) mem[aw] = wdata[owner*16 +: 16];
        if (acc) begin
`ifdef MEM_ARB_RR_EN
          ptr = owner;
`endif
          if (auto_drop) n_val[owner] = 1'b0;
        end
        own = !acc && val[owner];
      end else if (val != 3'b000) begin
        owner = winner(val, ptr);
        own = 1'b1;
      end
      rv_pend = rd;
    end
    n_mrdata = rd ? rv_data : 16'($urandom);
  endtask

  task automatic post(input int i, input bit w, input logic [7:0] a, input logic [15:0] d);
    n_val[i] = 1'b1; n_wen[i] = w; n_addr[i*8 +: 8] = a; n_wdata[i*16 +: 16] = d;
  endtask

  logic [2:0] g_hist [$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257);
    mem[8'h10] = 16'h1234;
    mem[8'h05] = 16'h0555;
    // reset with requests pending: outputs must stay quiet
    n_val = 3'b111; n_mrdy = 1'b1;
    cycle(); cycle();
    chk("rst_gnt", s_gnt, 3'b000);
    chk("rst_busy", s_busy, 1'b0);
    n_val = 3'b000; n_rst = 1'b0;
    cycle();

    // single core read
    post(1, 1'b0, 8'h10, 16'h0);
    cycle(); chk("t1_c1_gnt", s_gnt, 3'b000);
    cycle(); chk("t1_c2_gnt", s_gnt, 3'b010); chk("t1_c2_mval", s_mval, 1'b1);
    cycle(); chk("t1_c3_rv", s_rvalid, 3'b010); chk("t1_c3_rdata", s_rdata, 16'h1234);
    cycle(); chk("t1_c4_rv", s_rvalid, 3'b000);

    // panel write vs core read
    post(0, 1'b1, 8'h20, 16'hBEEF);
    post(1, 1'b0, 8'h10, 16'h0);
    cycle();
    cycle(); chk("t2_panel_gnt", s_gnt, 3'b001);
    cycle(); chk("t2_no_rv", s_rvalid, 3'b000);
    cycle(); chk("t2_core_gnt", s_gnt, 3'b010);
    cycle(); chk("t2_core_rv", s_rvalid, 3'b010); chk("t2_rdata", s_rdata, 16'h1234);
    cycle();

    // snapshot read stalled by the memory
    n_mrdy = 1'b0;
    post(2, 1'b0, 8'h05, 16'h0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle(); chk("t3_hold_gnt", s_gnt, 3'b100); chk("t3_hold_rv", s_rvalid, 3'b000);
    end
    n_mrdy = 1'b1;
    cycle(); chk("t3_acc_gnt", s_gnt, 3'b100);
    cycle(); chk("t3_rv", s_rvalid, 3'b100); chk("t3_rdata", s_rdata, 16'h0555);
    cycle();

    // owner withdraws before acceptance
    n_mrdy = 1'b0;
    post(1, 1'b0, 8'h30, 16'h0);
    cycle(); cycle();
    n_val[1] = 1'b0;
    cycle(); chk("t4_busy", s_busy, 1'b1); chk("t4_mval", s_mval, 1'b0);
    cycle(); chk("t4_idle", s_busy, 1'b0);
    cycle(); chk("t4_rv", s_rvalid, 3'b000);

    // reset mid-read, then normal arbitration
    post(1, 1'b0, 8'h10, 16'h0);
    cycle(); cycle();
    n_rst = 1'b1; n_mrdy = 1'b1;
    cycle(); chk("t5_rst_gnt", s_gnt, 3'b000); chk("t5_rst_mval", s_mval, 1'b0);
    n_rst = 1'b0;
    cycle(); chk("t5_idle_gnt", s_gnt, 3'b000); chk("t5_idle_rv", s_rvalid, 3'b000);
    cycle(); chk("t5_gnt", s_gnt, 3'b010);
    cycle(); chk("t5_rv", s_rvalid, 3'b010); chk("t5_rdata", s_rdata, 16'h1234);
    cycle();

    // all three requesting continuously
    auto_drop = 1'b0;
    post(0, 1'b0, 8'h01, 16'h0); post(1, 1'b0, 8'h02, 16'h0); post(2, 1'b0, 8'h03, 16'h0);
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_busy) g_hist.push_back(s_gnt);
    end
    chk("t6_grants", g_hist.size(), 6);
    for (int k = 0; k < g_hist.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      if (k > 0) chk("t6_rotate", (g_hist[k] == g_hist[k-1]), 1'b0);
      if (k > 1) chk("t6_cover", (g_hist[k] | g_hist[k-1] | g_hist[k-2]), 3'b111);
`else
      chk("t6_fixed", g_hist[k], 3'b001);
`endif
    end
    n_val = 3'b000; auto_drop = 1'b1;
    cycle(); cycle();

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      n_rst = ($urandom_range(0, 99) == 0);
      n_mrdy = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 3; i++) begin
        if (!n_val[i]) begin
          if ($urandom_range(0, 2) == 0)
            post(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
        end else if ($urandom_range(0, 39) == 0) begin
          n_val[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
